// File: rtl/tagger_control.sv
// tagger_control: acquisition sequencer and record buffer for event_tagger.
// A small IDLE/CLEAR/RUN FSM drives the tagger's reset/operate controls.
// Records are buffered in a first-word-fallthrough FIFO with drop counting.
module tagger_control #(
    parameter int RECORD_WIDTH   = 47,
    parameter int FIFO_DEPTH     = 16,
    parameter int RESET_CYCLES   = 3,
    parameter int DURATION_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            cmd_start,
    input  logic                            cmd_stop,
    input  logic [DURATION_WIDTH-1:0]       acq_duration,
    output logic                            tagger_reset_counter,
    output logic                            tagger_capture_operate,
    output logic                            tagger_counter_operate,
    input  logic [RECORD_WIDTH-1:0]         tagger_data,
    input  logic                            tagger_ready,
    output logic [RECORD_WIDTH-1:0]         out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            busy,
    output logic [15:0]                     lost_count,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CLR_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(RESET_CYCLES - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CLEAR = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;

    logic [1:0]                state_reg, state_next;
    logic [CLR_W-1:0]          clr_cnt_reg, clr_cnt_next;
    logic [DURATION_WIDTH-1:0] run_cnt_reg, run_cnt_next;
    logic [DURATION_WIDTH-1:0] duration_reg, duration_next;
    logic [DURATION_WIDTH-1:0] run_inc;
    logic                      start_ok;

    // A start is only honoured from IDLE and never together with a stop.
    assign start_ok = (state_reg == IDLE) && cmd_start && !cmd_stop;
    assign run_inc  = run_cnt_reg + 1'b1;

    // Next-state and counter logic for the acquisition sequencer.
    always_comb begin
        state_next    = state_reg;
        clr_cnt_next  = clr_cnt_reg;
        run_cnt_next  = run_cnt_reg;
        duration_next = duration_reg;
        case (state_reg)
            IDLE: begin
                if (start_ok) begin
                    state_next    = CLEAR;
                    clr_cnt_next  = '0;
                    run_cnt_next  = '0;
                    duration_next = acq_duration;
                end
            end
            CLEAR: begin
                if (cmd_stop) begin
                    state_next = IDLE;
                end else if (clr_cnt_reg == CLR_LAST) begin
                    state_next = RUN;
                end else begin
                    clr_cnt_next = clr_cnt_reg + 1'b1;
                end
            end
            RUN: begin
                run_cnt_next = run_inc;
                // Stop wins over expiry; duration 0 means run until stopped.
                if (cmd_stop) begin
                    state_next = IDLE;
                end else if ((duration_reg != '0) && (run_inc == duration_reg)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, counters and registered control outputs decoded from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg              <= IDLE;
            clr_cnt_reg            <= '0;
            run_cnt_reg            <= '0;
            duration_reg           <= '0;
            tagger_reset_counter   <= 1'b0;
            tagger_capture_operate <= 1'b0;
            tagger_counter_operate <= 1'b0;
            busy                   <= 1'b0;
        end else begin
            state_reg              <= state_next;
            clr_cnt_reg            <= clr_cnt_next;
            run_cnt_reg            <= run_cnt_next;
            duration_reg           <= duration_next;
            tagger_reset_counter   <= (state_next == CLEAR);
            tagger_capture_operate <= (state_next == RUN);
            tagger_counter_operate <= (state_next == RUN);
            busy                   <= (state_next != IDLE);
        end
    end

    // ------------------------------------------------------------------
    // Record FIFO
    // ------------------------------------------------------------------
    logic [RECORD_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_reg, rd_ptr_reg;
    logic                    full, pop, push, drop;

    // Occupancy is tracked by level, so equal pointers are unambiguous.
    assign out_valid = (fifo_level != '0);
    assign full      = (fifo_level == LVL_FULL);
    assign pop       = out_valid && out_ready;
    // A pop on the same cycle frees the slot, so a full FIFO still accepts.
    assign push      = tagger_ready && (!full || pop);
    assign drop      = tagger_ready && full && !pop;
    assign out_data  = mem[rd_ptr_reg];

    // Record storage; contents need no reset since level gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= tagger_data;
        end
    end

    // Pointers, level and the saturating drop counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            fifo_level <= '0;
            lost_count <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
            if (start_ok) begin
                lost_count <= '0;
            end else if (drop && (lost_count != 16'hFFFF)) begin
                lost_count <= lost_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_tagger_control.sv
// Testbench for tagger_control: table-driven control vectors, directed
// FIFO/overflow/reset sequences and randomized traffic against a timeline
// and queue based reference model.
module tb_tagger_control;

    localparam int RW = 47;
    localparam int DEPTH = 16;
    localparam int RC = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cmd_start = 1'b0;
    logic          cmd_stop = 1'b0;
    logic [31:0]   acq_duration = '0;
    logic          tagger_reset_counter;
    logic          tagger_capture_operate;
    logic          tagger_counter_operate;
    logic [RW-1:0] tagger_data = '0;
    logic          tagger_ready = 1'b0;
    logic [RW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          busy;
    logic [15:0]   lost_count;
    logic [4:0]    fifo_level;

    tagger_control #(
        .RECORD_WIDTH(RW), .FIFO_DEPTH(DEPTH), .RESET_CYCLES(RC), .DURATION_WIDTH(32)
    ) dut (
        .clk(clk), .reset_n(reset_n), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
        .acq_duration(acq_duration),
        .tagger_reset_counter(tagger_reset_counter),
        .tagger_capture_operate(tagger_capture_operate),
        .tagger_counter_operate(tagger_counter_operate),
        .tagger_data(tagger_data), .tagger_ready(tagger_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .lost_count(lost_count), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model: an acquisition is a timeline anchored at the start edge.
    longint        cyc = 0;
    bit            m_active = 0;
    longint        m_start = 0;
    longint        m_dur = 0;
    int            m_lost = 0;
    logic [RW-1:0] q[$];

    function automatic bit m_rc();
        longint k = cyc - m_start;
        return m_active && k >= 1 && k <= RC;
    endfunction

    function automatic bit m_op();
        longint k = cyc - m_start;
        return m_active && k > RC && (m_dur == 0 || k <= RC + m_dur);
    endfunction

    function automatic bit m_busy();
        longint k = cyc - m_start;
        return m_active && k >= 1 && (m_dur == 0 || k <= RC + m_dur);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0;
        m_lost = 0;
        q.delete();
    endtask

    // Apply the current inputs to the model as if one clock edge happened.
    task automatic model_edge();
        bit was_busy = m_busy();
        bit pop = (q.size() != 0) && out_ready;
        bit full = (q.size() == DEPTH);
        if (tagger_ready && full && !pop && m_lost < 16'hFFFF) m_lost++;
        if (pop) void'(q.pop_front());
        if (tagger_ready && (!full || pop)) q.push_back(tagger_data);
        if (was_busy && cmd_stop) m_active = 0;
        if (!was_busy && cmd_start && !cmd_stop) begin
            m_lost = 0;
            m_active = 1;
            m_start = cyc;
            m_dur = longint'(acq_duration);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".reset_counter"}, 64'(tagger_reset_counter), 64'(m_rc()));
        chk({tag, ".capture_op"}, 64'(tagger_capture_operate), 64'(m_op()));
        chk({tag, ".counter_op"}, 64'(tagger_counter_operate), 64'(m_op()));
        chk({tag, ".busy"}, 64'(busy), 64'(m_busy()));
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(q.size() != 0));
        chk({tag, ".fifo_level"}, 64'(fifo_level), 64'(q.size()));
        chk({tag, ".lost_count"}, 64'(lost_count), 64'(m_lost));
        if (q.size() != 0) chk({tag, ".out_data"}, 64'(out_data), 64'(q[0]));
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        check_model(tag);
    endtask

    typedef struct {
        logic        start;
        logic        stop;
        logic [31:0] dur;
        logic        rc;
        logic        op;
        logic        bsy;
    } vec_t;

    vec_t tbl[15];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int op_cycles;
        bit seen_idle;

        // Control vectors from IDLE: default start/stop, ignored commands, D=2 run.
        tbl[0]  = '{1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 32'd5, 1'b0, 1'b1, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 32'd2, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1};
        tbl[13] = '{1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0};

        // Reset held for 5 cycles.
        repeat (5) @(posedge clk);
        #1;
        chk("reset.busy", 64'(busy), 64'd0);
        chk("reset.op", 64'(tagger_capture_operate), 64'd0);
        reset_n = 1'b1;
        model_reset();
        check_model("after_reset");
        $display("reset: level=%0d lost=%0d busy=%0d", fifo_level, lost_count, busy);

        // Table-driven control vectors.
        for (int i = 0; i < 15; i++) begin
            cmd_start = tbl[i].start;
            cmd_stop = tbl[i].stop;
            acq_duration = tbl[i].dur;
            step("tbl");
            chk($sformatf("tbl[%0d].rc", i), 64'(tagger_reset_counter), 64'(tbl[i].rc));
            chk($sformatf("tbl[%0d].op", i), 64'(tagger_counter_operate), 64'(tbl[i].op));
            chk($sformatf("tbl[%0d].busy", i), 64'(busy), 64'(tbl[i].bsy));
            $display("vec %0d: start=%0b stop=%0b dur=%0d -> rc=%0b op=%0b busy=%0b",
                     i, tbl[i].start, tbl[i].stop, tbl[i].dur,
                     tagger_reset_counter, tagger_counter_operate, busy);
        end
        cmd_start = 0; cmd_stop = 0; acq_duration = 0;

        // Timed run of 100 cycles with an ignored start in the middle.
        cmd_start = 1; acq_duration = 32'd100;
        step("timed");
        cmd_start = 0; acq_duration = 32'd7;
        op_cycles = 0;
        seen_idle = 0;
        for (int i = 0; i < 300 && !seen_idle; i++) begin
            cmd_start = (i == 50);
            step("timed");
            if (tagger_capture_operate) op_cycles++;
            if (!busy) seen_idle = 1;
        end
        cmd_start = 0; acq_duration = 0;
        chk("timed.op_cycles", 64'(op_cycles), 64'd100);
        chk("timed.returned_idle", 64'(seen_idle), 64'd1);
        $display("timed run: operate cycles=%0d", op_cycles);

        // Ordering under backpressure.
        for (int i = 1; i <= 10; i++) begin
            tagger_ready = 1; tagger_data = RW'(i);
            step("order_fill");
        end
        tagger_ready = 0;
        chk("order.level10", 64'(fifo_level), 64'd10);
        out_ready = 1;
        for (int i = 1; i <= 10; i++) begin
            chk($sformatf("order.data%0d", i), 64'(out_data), 64'(i));
            chk($sformatf("order.valid%0d", i), 64'(out_valid), 64'd1);
            step("order_drain");
        end
        out_ready = 0;
        chk("order.valid_fall", 64'(out_valid), 64'd0);
        $display("ordering: 10 records drained, level=%0d", fifo_level);

        // Overflow, full push+pop, then start clears the drop count.
        for (int i = 1; i <= 20; i++) begin
            tagger_ready = 1; tagger_data = RW'(i);
            step("ovf_fill");
        end
        chk("ovf.level", 64'(fifo_level), 64'd16);
        chk("ovf.lost", 64'(lost_count), 64'd4);
        tagger_data = RW'(99); out_ready = 1;
        step("ovf_pushpop");
        tagger_ready = 0; out_ready = 0;
        chk("ovf.pushpop_lost", 64'(lost_count), 64'd4);
        chk("ovf.pushpop_level", 64'(fifo_level), 64'd16);
        chk("ovf.pushpop_head", 64'(out_data), 64'd2);
        cmd_start = 1;
        step("ovf_start");
        cmd_start = 0;
        chk("ovf.start_clears_lost", 64'(lost_count), 64'd0);
        chk("ovf.start_keeps_fifo", 64'(fifo_level), 64'd16);
        cmd_stop = 1;
        step("ovf_stop");
        cmd_stop = 0;
        out_ready = 1;
        for (int i = 0; i < 17; i++) step("ovf_drain");
        out_ready = 0;
        $display("overflow: lost cleared on start, drained level=%0d", fifo_level);

        // Reset asserted mid-run with records buffered.
        cmd_start = 1;
        step("rst_run");
        cmd_start = 0;
        for (int i = 0; i < 5; i++) step("rst_run");
        for (int i = 0; i < 5; i++) begin
            tagger_ready = 1; tagger_data = RW'(100 + i);
            step("rst_fill");
        end
        tagger_ready = 0;
        chk("rst.level_before", 64'(fifo_level), 64'd5);
        chk("rst.op_before", 64'(tagger_capture_operate), 64'd1);
        #2;
        reset_n = 0;
        #1;
        chk("rst.op_async", 64'(tagger_capture_operate), 64'd0);
        chk("rst.cnt_async", 64'(tagger_counter_operate), 64'd0);
        chk("rst.level_async", 64'(fifo_level), 64'd0);
        chk("rst.lost_async", 64'(lost_count), 64'd0);
        chk("rst.valid_async", 64'(out_valid), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        cyc++;
        reset_n = 1;
        check_model("rst_release");
        $display("mid-run reset: op=%0b level=%0d", tagger_capture_operate, fifo_level);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cmd_start = ($urandom_range(15) == 0);
            cmd_stop = ($urandom_range(39) == 0);
            acq_duration = ($urandom_range(3) == 0) ? 32'd0 : 32'($urandom_range(1, 40));
            tagger_ready = ($urandom_range(1) == 0);
            tagger_data = {$urandom, $urandom};
            out_ready = ($urandom_range(2) == 0);
            step("rand");
        end
        cmd_start = 0; cmd_stop = 0; tagger_ready = 0; out_ready = 0;
        $display("random: 3000 cycles applied");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
